opa_stage: RTL and testbench
============================

Name: opa_stage

Overview:
- Parametrised, registered successor to the combinational operand-A mux in the RISC-V datapath.
- Selects operand A from one of four sources: rs1 register data, PC, zero (LUI), or a forwarded pipeline result.
- Captures the selected value into an ID/EX-style pipeline register with a valid/ready handshake, stall and flush.
- Sits between decode and the ALU input of the pipelined core.

Parameters:
- XLEN, 32, datapath width in bits.
- NUM_FWD, 2, number of forwarding sources; index 0 is the youngest (EX/MEM), higher indices are older (MEM/WB, ...).
- RADDR_W, 5, register-address width.

Ports:
- clk  input  1  core clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  decode presents a valid instruction.
- in_ready  output  1  stage can accept this cycle.
- rs1_data  input  XLEN  register-file read data.
- rs1_addr  input  RADDR_W  rs1 index used for forwarding match.
- pc  input  XLEN  instruction PC.
- opa_sel  input  2  00 = rs1, 01 = pc, 10 = zero, 11 = reserved (treated as zero).
- fwd_wen  input  NUM_FWD  per-source write-enable.
- fwd_addr  input  NUM_FWD*RADDR_W  per-source destination register.
- fwd_data  input  NUM_FWD*XLEN  per-source result.
- flush  input  1  squash the held and incoming instruction.
- out_valid  output  1  operand_a valid toward EX.
- out_ready  input  1  EX accepts; low = stall.
- operand_a  output  XLEN  registered operand A.
- fwd_hit  output  1  registered flag: the captured operand came from a forwarding source.

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - out_valid = 0, operand_a = 0, fwd_hit = 0.
  - All are driven from the register, so reset takes effect immediately, including mid-stall.
- in_ready = !out_valid || out_ready. It is combinational and has no dependence on in_valid.
- Load condition: in_valid && in_ready && !flush.
- On load, the next cycle has out_valid = 1, operand_a = selected value, and fwd_hit set accordingly. Latency is exactly 1 cycle.
- Hold: if out_valid && !out_ready, operand_a, fwd_hit and out_valid stay frozen. Forwarding inputs changing during a stall have no effect on held data.
- Drain: out_valid && out_ready && no load gives out_valid = 0 next cycle. operand_a holds its stale value, which is don't-care.
- flush: out_valid = 0 next cycle regardless of stall, in_valid or load. flush wins over a simultaneous load. operand_a is not required to change.
- Selection for opa_sel = 00:
  - Scan sources 0..NUM_FWD-1.
  - The first i with fwd_wen[i] && fwd_addr[i] == rs1_addr && rs1_addr != 0 supplies fwd_data[i], with fwd_hit = 1.
  - The lowest index wins when several match.
  - No match gives rs1_data, with fwd_hit = 0.
- Selection for opa_sel = 01 gives pc; 10 and 11 give 0. fwd_hit = 0 for all three, even when a forwarding address matches.
- x0 is never forwarded. With rs1_addr = 0, the result is rs1_data (which the regfile drives as 0).
- No arithmetic. Widths are passed through unchanged, with no truncation or extension.

Optional Feature:
- Macro: OPA_FWD_EN.
- Defined: forwarding logic as described above.
- Undefined:
  - fwd_* ports remain present but are ignored.
  - opa_sel = 00 always yields rs1_data.
  - fwd_hit is tied to 0.
  - The handshake is unchanged.

Decomposition:
- Shared package core_pkg:
  - typedef opa_sel_e (OPA_RS1 = 2'b00, OPA_PC = 2'b01, OPA_ZERO = 2'b10, OPA_RSVD = 2'b11).
  - localparam XLEN_DEF = 32.
  - localparam RADDR_W_DEF = 5.
- One sub-module, fwd_prio_sel: purely combinational priority match over NUM_FWD sources, returning hit and data. It is reused later for operand B.
- The opa_stage top level holds the mux and the pipeline register.

Test Plan:
- Reset, then release with no stimulus -> out_valid = 0, operand_a = 0, in_ready = 1.
- Basic selection (each case takes 1 cycle):
  - rs1_data = 0xffffffaa, pc = 0x00000005, opa_sel = 01, in_valid = 1 -> operand_a = 0x00000005, fwd_hit = 0.
  - Same inputs with opa_sel = 00 -> operand_a = 0xffffffaa.
  - opa_sel = 10 -> operand_a = 0.
- Forwarding priority, with rs1_addr = 3, fwd_wen = 2'b11, fwd_addr = {3,3}, fwd_data = {0x22222222, 0x11111111} (source 0 = 0x11111111), opa_sel = 00:
  - Expect operand_a = 0x11111111, fwd_hit = 1.
  - Clear fwd_wen[0] -> 0x22222222.
  - Set rs1_addr = 0 -> rs1_data, fwd_hit = 0.
- Stall: load 0xA5A5A5A5, hold out_ready = 0 for 3 cycles while changing all inputs:
  - in_ready = 0 throughout, operand_a stays 0xA5A5A5A5, out_valid stays 1.
  - Raise out_ready -> the next input loads in the same cycle.
- Flush during stall together with in_valid = 1 -> out_valid = 0 next cycle, and nothing is loaded.
- Assert rst_n = 0 asynchronously mid-stall, between clock edges -> out_valid and operand_a go to 0 immediately. With OPA_FWD_EN undefined, rerun the forwarding scenario and expect rs1_data with fwd_hit = 0.

Source files
------------

// File: rtl/core_pkg.sv
// Shared datapath types and defaults for the pipelined core.
// Operand-select encoding and default widths used by opa_stage and fwd_prio_sel.
package core_pkg;

    typedef enum logic [1:0] {
        OPA_RS1  = 2'b00,
        OPA_PC   = 2'b01,
        OPA_ZERO = 2'b10,
        OPA_RSVD = 2'b11
    } opa_sel_e;

    localparam int XLEN_DEF    = 32;
    localparam int RADDR_W_DEF = 5;

endpackage

// File: rtl/fwd_prio_sel.sv
// Combinational priority match of a source register against NUM_FWD forwarding ports.
// Source 0 is the youngest result and wins when several ports match; x0 never matches.
module fwd_prio_sel
    import core_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int NUM_FWD = 2,
    parameter int RADDR_W = RADDR_W_DEF
) (
    input  logic [RADDR_W-1:0]         rs_addr,
    input  logic [NUM_FWD-1:0]         fwd_wen,
    input  logic [NUM_FWD*RADDR_W-1:0] fwd_addr,
    input  logic [NUM_FWD*XLEN-1:0]    fwd_data,
    output logic                       hit,
    output logic [XLEN-1:0]            data
);

    // Walk oldest to youngest so the lowest matching index is the last writer.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (fwd_wen[i] && (fwd_addr[i*RADDR_W +: RADDR_W] == rs_addr) && (rs_addr != '0)) begin
                hit  = 1'b1;
                data = fwd_data[i*XLEN +: XLEN];
            end
        end
    end

endmodule

// File: rtl/opa_stage.sv
// Registered operand-A select (rs1 / pc / zero / forwarded result) feeding the ALU.
// Forwarding is enabled by defining OPA_FWD_EN; otherwise fwd_* inputs are ignored.
module opa_stage
    import core_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int NUM_FWD = 2,
    parameter int RADDR_W = RADDR_W_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [XLEN-1:0]            rs1_data,
    input  logic [RADDR_W-1:0]         rs1_addr,
    input  logic [XLEN-1:0]            pc,
    input  logic [1:0]                 opa_sel,
    input  logic [NUM_FWD-1:0]         fwd_wen,
    input  logic [NUM_FWD*RADDR_W-1:0] fwd_addr,
    input  logic [NUM_FWD*XLEN-1:0]    fwd_data,
    input  logic                       flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [XLEN-1:0]            operand_a,
    output logic                       fwd_hit
);

    // Handshake: a transfer happens on a rising edge where valid && ready.
    // The stage accepts whenever its register is empty or being drained this
    // cycle; in_ready never looks at in_valid, and flush blocks any load.

    logic                 out_valid_q, out_valid_d;
    logic [XLEN-1:0]      operand_a_q, operand_a_d;
    logic                 fwd_hit_q, fwd_hit_d;

    logic [NUM_FWD-1:0]   fwd_wen_eff;
    logic                 prio_hit;
    logic [XLEN-1:0]      prio_data;
    logic [XLEN-1:0]      sel_val;
    logic                 sel_hit;
    logic                 load;

`ifdef OPA_FWD_EN
    assign fwd_wen_eff = fwd_wen;
`else
    // Masking the enables disables every match while keeping the ports read.
    assign fwd_wen_eff = fwd_wen & {NUM_FWD{1'b0}};
`endif

    fwd_prio_sel #(
        .XLEN    (XLEN),
        .NUM_FWD (NUM_FWD),
        .RADDR_W (RADDR_W)
    ) u_fwd_prio_sel (
        .rs_addr  (rs1_addr),
        .fwd_wen  (fwd_wen_eff),
        .fwd_addr (fwd_addr),
        .fwd_data (fwd_data),
        .hit      (prio_hit),
        .data     (prio_data)
    );

    always_comb begin
        sel_val = '0;
        sel_hit = 1'b0;
        case (opa_sel_e'(opa_sel))
            OPA_RS1: begin
                if (prio_hit) begin
                    sel_val = prio_data;
                    sel_hit = 1'b1;
                end else begin
                    sel_val = rs1_data;
                end
            end
            OPA_PC:  sel_val = pc;
            default: sel_val = '0;
        endcase
    end

    assign in_ready = !out_valid_q || out_ready;
    assign load     = in_valid && in_ready && !flush;

    always_comb begin
        out_valid_d = out_valid_q;
        operand_a_d = operand_a_q;
        fwd_hit_d   = fwd_hit_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (load) begin
            out_valid_d = 1'b1;
            operand_a_d = sel_val;
            fwd_hit_d   = sel_hit;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            operand_a_q <= '0;
            fwd_hit_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            operand_a_q <= operand_a_d;
            fwd_hit_q   <= fwd_hit_d;
        end
    end

    assign out_valid = out_valid_q;
    assign operand_a = operand_a_q;
    assign fwd_hit   = fwd_hit_q;

endmodule

// File: tb/tb_opa_stage.sv
// Self-checking bench for opa_stage: scoreboard of {fwd_hit, operand_a} per accepted input.
// Expectations follow OPA_FWD_EN so the same bench covers both builds.
module tb_opa_stage;

    localparam int XLEN    = 32;
    localparam int NUM_FWD = 2;
    localparam int RADDR_W = 5;

    logic                       clk;
    logic                       rst_n;
    logic                       in_valid;
    logic                       in_ready;
    logic [XLEN-1:0]            rs1_data;
    logic [RADDR_W-1:0]         rs1_addr;
    logic [XLEN-1:0]            pc;
    logic [1:0]                 opa_sel;
    logic [NUM_FWD-1:0]         fwd_wen;
    logic [NUM_FWD*RADDR_W-1:0] fwd_addr;
    logic [NUM_FWD*XLEN-1:0]    fwd_data;
    logic                       flush;
    logic                       out_valid;
    logic                       out_ready;
    logic [XLEN-1:0]            operand_a;
    logic                       fwd_hit;

    int n_vec = 0;
    int n_err = 0;

    logic [XLEN:0] exp_q[$];
    logic          mdl_valid;
    logic          mdl_load;

    opa_stage #(
        .XLEN    (XLEN),
        .NUM_FWD (NUM_FWD),
        .RADDR_W (RADDR_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .rs1_data  (rs1_data),
        .rs1_addr  (rs1_addr),
        .pc        (pc),
        .opa_sel   (opa_sel),
        .fwd_wen   (fwd_wen),
        .fwd_addr  (fwd_addr),
        .fwd_data  (fwd_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .operand_a (operand_a),
        .fwd_hit   (fwd_hit)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish (got running, expected finished)");
        $fatal(1);
    end

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: {hit, value} for the current inputs.
    function automatic logic [XLEN:0] model_opa(
        input logic [1:0]                 sel,
        input logic [XLEN-1:0]            r1d,
        input logic [RADDR_W-1:0]         r1a,
        input logic [XLEN-1:0]            p,
        input logic [NUM_FWD-1:0]         wen,
        input logic [NUM_FWD*RADDR_W-1:0] fa,
        input logic [NUM_FWD*XLEN-1:0]    fd
    );
        logic [XLEN:0] r;
        logic          found;
        logic          fwd_en;
`ifdef OPA_FWD_EN
        fwd_en = 1'b1;
`else
        fwd_en = 1'b0;
`endif
        found = 1'b0;
        r     = '0;
        if (sel == 2'b01) begin
            r = {1'b0, p};
        end else if (sel == 2'b00) begin
            r = {1'b0, r1d};
            for (int i = 0; i < NUM_FWD; i++) begin
                if (fwd_en && !found && (r1a != 0) && wen[i] && (fa[i*RADDR_W +: RADDR_W] == r1a)) begin
                    r     = {1'b1, fd[i*XLEN +: XLEN]};
                    found = 1'b1;
                end
            end
        end
        return r;
    endfunction

    // ---------------- scoreboard push / valid model ----------------
    assign mdl_load = in_valid && (!mdl_valid || out_ready) && !flush;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdl_valid <= 1'b0;
            exp_q.delete();
        end else begin
            if (flush && mdl_valid && exp_q.size() > 0)
                void'(exp_q.pop_front());
            if (mdl_load)
                exp_q.push_back(model_opa(opa_sel, rs1_data, rs1_addr, pc, fwd_wen, fwd_addr, fwd_data));
            if (flush)
                mdl_valid <= 1'b0;
            else if (mdl_load)
                mdl_valid <= 1'b1;
            else if (out_ready)
                mdl_valid <= 1'b0;
        end
    end

    // ---------------- monitor / scoreboard compare ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            check("in_ready", in_ready, !mdl_valid || out_ready);
            check("out_valid", out_valid, mdl_valid);
            if (out_valid && out_ready && !flush) begin
                if (exp_q.size() == 0) begin
                    check("sb_underflow", 1, 0);
                end else begin
                    check("operand_a", operand_a, exp_q[0][XLEN-1:0]);
                    check("fwd_hit", fwd_hit, exp_q[0][XLEN]);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0;
        flush    = 1'b0;
        fwd_wen  = '0;
        opa_sel  = 2'b00;
    endtask

    task automatic randomize_inputs();
        rs1_data = $urandom;
        rs1_addr = RADDR_W'($urandom_range(0, 3));
        pc       = $urandom;
        opa_sel  = 2'($urandom_range(0, 3));
        fwd_wen  = NUM_FWD'($urandom_range(0, 3));
        fwd_addr = {RADDR_W'($urandom_range(0, 3)), RADDR_W'($urandom_range(0, 3))};
        fwd_data = {$urandom, $urandom};
    endtask

    task automatic fwd_scenario();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        flush     = 1'b0;
        opa_sel   = 2'b00;
        rs1_data  = 32'hdeadbeef;
        rs1_addr  = 5'd3;
        fwd_wen   = 2'b11;
        fwd_addr  = {5'd3, 5'd3};
        fwd_data  = {32'h22222222, 32'h11111111};
        step();
        fwd_wen   = 2'b10;
        step();
        rs1_addr  = 5'd0;
        rs1_data  = 32'h00000000;
        fwd_wen   = 2'b11;
        fwd_addr  = {5'd0, 5'd0};
        step();
        rs1_addr  = 5'd3;
        fwd_addr  = {5'd3, 5'd3};
        opa_sel   = 2'b01;
        pc        = 32'h00001000;
        step();
        in_valid  = 1'b0;
        step();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n     = 1'b0;
        out_ready = 1'b1;
        rs1_data  = '0;
        rs1_addr  = '0;
        pc        = '0;
        fwd_addr  = '0;
        fwd_data  = '0;
        idle_inputs();
        #12;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_operand_a", operand_a, 0);
        check("rst_fwd_hit", fwd_hit, 0);
        check("rst_in_ready", in_ready, 1);
        step();

        // basic selection
        in_valid = 1'b1;
        rs1_data = 32'hffffffaa;
        rs1_addr = 5'd7;
        pc       = 32'h00000005;
        opa_sel  = 2'b01;
        step();
        @(negedge clk);
        check("sel_pc_direct", operand_a, 32'h00000005);
        opa_sel = 2'b00;
        step();
        @(negedge clk);
        check("sel_rs1_direct", operand_a, 32'hffffffaa);
        opa_sel = 2'b10;
        step();
        @(negedge clk);
        check("sel_zero_direct", operand_a, 0);
        opa_sel = 2'b11;
        step();
        idle_inputs();
        step();

        fwd_scenario();

        // stall: hold a loaded value while every input moves
        in_valid = 1'b1;
        opa_sel  = 2'b00;
        rs1_addr = 5'd0;
        rs1_data = 32'hA5A5A5A5;
        fwd_wen  = '0;
        step();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            randomize_inputs();
            in_valid = 1'b1;
            @(negedge clk);
            check("stall_in_ready", in_ready, 0);
            check("stall_out_valid", out_valid, 1);
            check("stall_operand_a", operand_a, 32'hA5A5A5A5);
            step();
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        opa_sel   = 2'b00;
        rs1_addr  = 5'd0;
        rs1_data  = 32'h12345678;
        fwd_wen   = '0;
        step();
        in_valid = 1'b0;
        @(negedge clk);
        check("unstall_load", operand_a, 32'h12345678);
        step();

        // flush during a stall with a competing input
        in_valid = 1'b1;
        rs1_data = 32'h0F0F0F0F;
        step();
        out_ready = 1'b0;
        flush     = 1'b1;
        rs1_data  = 32'hBAD0BAD0;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("flush_squash", out_valid, 0);
        out_ready = 1'b1;
        step();

        // asynchronous reset in the middle of a stall
        in_valid = 1'b1;
        rs1_data = 32'h5A5A5A5A;
        step();
        out_ready = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", out_valid, 0);
        check("async_rst_operand_a", operand_a, 0);
        check("async_rst_fwd_hit", fwd_hit, 0);
        @(negedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        idle_inputs();
        step();

        fwd_scenario();

        // random traffic with stalls and flushes
        for (int i = 0; i < 300; i++) begin
            randomize_inputs();
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 9) == 0);
            step();
        end

        idle_inputs();
        out_ready = 1'b1;
        repeat (3) step();
        check("drain_queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
